// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and pad-value helper for the sort pipeline stages
package sort_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } sort_state_e;

   localparam int PAD_MAX_W = 256;

   // Pad slots sort to the end of an ascending batch; callers truncate to their width.
   function automatic logic [PAD_MAX_W-1:0] pad_word();
      return '1;
   endfunction

endpackage

// File: rtl/sort_input_loader.sv
// rtl/sort_input_loader.sv - serial-to-parallel batch loader feeding the sorter
// Optional watchdog on the sortdone wait: SORT_LOADER_TIMEOUT_EN.
module sort_input_loader
   import sort_pkg::*;
#(
   parameter int INPUTVALS      = 16,
   parameter int INPUTBITWIDTHS = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     in_valid,
   input  logic [INPUTBITWIDTHS-1:0]                in_data,
   output logic                                     in_ready,
   input  logic                                     flush,
   output logic                                     sortstart,
   output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] needs_sorting,
   output logic [$clog2(INPUTVALS):0]               valid_count,
   input  logic                                     sortdone,
   output logic                                     error
);

   localparam int IDXW = $clog2(INPUTVALS);
   localparam int CW   = IDXW + 1;
   localparam logic [INPUTBITWIDTHS-1:0] PAD_VALUE = INPUTBITWIDTHS'(pad_word());

   if (INPUTVALS < 2 || TIMEOUT_CYCLES < 1 || INPUTBITWIDTHS > PAD_MAX_W) begin : g_cfg_check
      $error("sort_input_loader: illegal parameter set");
   end

   sort_state_e                             state_q, state_d;
   logic [IDXW-1:0]                         wr_idx_q, wr_idx_d;
   logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] slots_q, slots_d;
   logic [CW-1:0]                           count_q, count_d;
   logic                                    error_q, error_d;
   logic [CW-1:0]                           count_now;
   logic                                    beat;
   logic                                    tmo_expired;

`ifdef SORT_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = '0;
      if (state_q == ST_WAIT) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign tmo_expired = (state_q == ST_WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_LOAD;
         wr_idx_q <= '0;
         slots_q  <= '0;
         count_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_idx_q <= wr_idx_d;
         slots_q  <= slots_d;
         count_q  <= count_d;
         error_q  <= error_d;
      end
   end

   assign beat      = in_valid & in_ready;
   assign count_now = CW'(wr_idx_q) + CW'(beat);

   always_comb begin
      state_d  = state_q;
      wr_idx_d = wr_idx_q;
      slots_d  = slots_q;
      count_d  = count_q;
      error_d  = error_q;
      case (state_q)
         ST_LOAD: begin
            if (beat) begin
               slots_d[wr_idx_q] = in_data;
               wr_idx_d          = wr_idx_q + 1'b1;
            end
            if (beat && (wr_idx_q == IDXW'(INPUTVALS - 1))) begin
               count_d  = CW'(INPUTVALS);
               wr_idx_d = '0;
               state_d  = ST_START;
            end else if (flush && (count_now != '0)) begin
               // Same-cycle beat is already in slots_d; only slots past it get padded.
               for (int i = 0; i < INPUTVALS; i++) begin
                  if (CW'(i) >= count_now) begin
                     slots_d[i] = PAD_VALUE;
                  end
               end
               count_d  = count_now;
               wr_idx_d = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sortdone) begin
               state_d = ST_LOAD;
            end else if (tmo_expired) begin
               error_d = 1'b1;
               state_d = ST_LOAD;
            end
         end
         default: begin
            error_d  = 1'b1;
            wr_idx_d = '0;
            state_d  = ST_LOAD;
         end
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      sortstart = (state_q == ST_START);
   end

   assign needs_sorting = slots_q;
   assign valid_count   = count_q;
   assign error         = error_q;

endmodule
